// File: rtl/wb_bypass_tracker_pkg.sv
// Shared types for the decode-stage bypass producer: result entries and GPR addressing.
package wb_bypass_tracker_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    word_t      value;
  } write_reg_t;

  localparam int         BYPASS_DEPTH = 6;
  localparam creg_addr_t ZERO_REG     = 5'd0;

  // r0 writes are architecturally dead, so they never forward or commit.
  function automatic write_reg_t capture(input write_reg_t w);
    write_reg_t r;
    r       = w;
    r.valid = w.valid && (w.dst != ZERO_REG);
    return r;
  endfunction
endpackage

// File: rtl/wb_bypass_tracker_gpr_file.sv
// 32x32 register file: two ordered write ports (port 1 wins) and NREAD async reads; r0 is zero.
module gpr_file
  import wb_bypass_tracker_pkg::*;
#(
  parameter int NREAD = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic       [1:0]             we_i,
  input  creg_addr_t [1:0]             waddr_i,
  input  word_t      [1:0]             wdata_i,
  input  creg_addr_t [NREAD-1:0]       raddr_i,
  output word_t      [NREAD-1:0]       rdata_o
);
  word_t regs_q [32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      if (we_i[0] && waddr_i[0] != ZERO_REG) regs_q[waddr_i[0]] <= wdata_i[0];
      if (we_i[1] && waddr_i[1] != ZERO_REG) regs_q[waddr_i[1]] <= wdata_i[1];
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    assign rdata_o[k] = (raddr_i[k] == ZERO_REG) ? '0 : regs_q[raddr_i[k]];
  end
endmodule

// File: rtl/wb_bypass_tracker.sv
// Carries dual-issue results EX -> MEM -> WB, exposes them youngest-first for forwarding,
// and commits WB into the GPR.
module wb_bypass_tracker
  import wb_bypass_tracker_pkg::*;
#(
  parameter int NREAD = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           stall,
  input  logic                           flush,
  input  write_reg_t [1:0]               ex_wr,
  input  logic       [1:0]               mem_ld_valid,
  input  word_t      [1:0]               mem_ld_data,
  input  creg_addr_t [NREAD-1:0]         rd_addr,
  output word_t      [NREAD-1:0]         rd_data,
  output write_reg_t [BYPASS_DEPTH-1:0]  write_reg
);
  write_reg_t [1:0] mem_q, mem_d, wb_q, wb_d, ex_view;
  logic             commit;

  // WB always drains on flush: the faulting instruction has already left MEM.
  assign commit = flush | ~stall;

  always_comb begin
    mem_d = mem_q;
    wb_d  = wb_q;
    if (flush) begin
      wb_d = mem_q;
      for (int i = 0; i < 2; i++) wb_d[i].valid = 1'b0;
      mem_d = '0;
    end else if (stall) begin
      for (int i = 0; i < 2; i++)
        if (mem_ld_valid[i]) mem_d[i].value = mem_ld_data[i];
    end else begin
      for (int i = 0; i < 2; i++) begin
        wb_d[i] = mem_q[i];
        if (mem_ld_valid[i]) wb_d[i].value = mem_ld_data[i];
        mem_d[i] = capture(ex_wr[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // EX is live; masking it by reset keeps the whole vector quiet while reset is held.
  for (genvar i = 0; i < 2; i++) begin : g_ex
    assign ex_view[i] = resetn ? capture(ex_wr[i]) : '0;
  end

  assign write_reg[0] = ex_view[1];
  assign write_reg[1] = ex_view[0];
  assign write_reg[2] = mem_q[1];
  assign write_reg[3] = mem_q[0];
  assign write_reg[4] = wb_q[1];
  assign write_reg[5] = wb_q[0];

  gpr_file #(.NREAD(NREAD)) u_gpr (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    ({wb_q[1].valid & commit, wb_q[0].valid & commit}),
    .waddr_i ({wb_q[1].dst, wb_q[0].dst}),
    .wdata_i ({wb_q[1].value, wb_q[0].value}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );
endmodule

// File: tb/tb_wb_bypass_tracker.sv
// Directed checks of bypass ordering, commit latency, stall/flush and async reset.
module tb_wb_bypass_tracker;
  import wb_bypass_tracker_pkg::*;
  localparam int NREAD = 4;

  logic                          clk = 1'b0;
  logic                          resetn = 1'b0;
  logic                          stall = 1'b0;
  logic                          flush = 1'b0;
  write_reg_t [1:0]              ex_wr = '0;
  logic       [1:0]              mem_ld_valid = '0;
  word_t      [1:0]              mem_ld_data = '0;
  creg_addr_t [NREAD-1:0]        rd_addr = '0;
  word_t      [NREAD-1:0]        rd_data;
  write_reg_t [BYPASS_DEPTH-1:0] write_reg;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  wb_bypass_tracker #(.NREAD(NREAD)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush), .ex_wr(ex_wr),
    .mem_ld_valid(mem_ld_valid), .mem_ld_data(mem_ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .write_reg(write_reg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic write_reg_t wr(input logic v, input creg_addr_t d, input word_t val);
    write_reg_t r;
    r.valid = v; r.dst = d; r.value = val;
    return r;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; ex_wr = '0;
    mem_ld_valid = '0; mem_ld_data = '0; rd_addr = '0;
    #12;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < BYPASS_DEPTH; i++) begin
      tot_cnt++;
      if (write_reg[i] !== '0) $display("FAIL reset_write_reg[%0d] got %h want 0", i, write_reg[i]);
      else pass_cnt++;
    end
    rd_addr = '{5'd9, 5'd5, 5'd1, 5'd31};
    #1;
    for (int k = 0; k < NREAD; k++) begin
      tot_cnt++;
      if (rd_data[k] !== 32'h0) $display("FAIL reset_rd_data[%0d] got %h want 0", k, rd_data[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic_flow();
    do_reset();
    rd_addr[0] = 5'd5;
    ex_wr[0] = wr(1'b1, 5'd5, 32'h11);
    #1;
    tot_cnt++;
    if (!(write_reg[1].valid === 1'b1 && write_reg[1].dst === 5'd5))
      $display("FAIL basic_c0_wr1 got %h want valid dst 5", write_reg[1]);
    else pass_cnt++;
    tick();
    ex_wr = '0;
    #1;
    tot_cnt++;
    if (write_reg[3] !== wr(1'b1, 5'd5, 32'h11)) $display("FAIL basic_c1_wr3 got %h", write_reg[3]);
    else pass_cnt++;
    tick();
    tot_cnt++;
    if (write_reg[5] !== wr(1'b1, 5'd5, 32'h11)) $display("FAIL basic_c2_wr5 got %h", write_reg[5]);
    else pass_cnt++;
    tot_cnt++;
    if (rd_data[0] !== 32'h0) $display("FAIL basic_c2_no_writethrough got %h want 0", rd_data[0]);
    else pass_cnt++;
    tick();
    tot_cnt++;
    if (rd_data[0] !== 32'h11) $display("FAIL basic_c3_gpr5 got %h want 11", rd_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_same_dst();
    do_reset();
    rd_addr[1] = 5'd7;
    ex_wr[0] = wr(1'b1, 5'd7, 32'hA);
    ex_wr[1] = wr(1'b1, 5'd7, 32'hB);
    #1;
    tot_cnt++;
    if (write_reg[0].value !== 32'hB || write_reg[1].value !== 32'hA)
      $display("FAIL samedst_order got %h/%h want b/a", write_reg[0].value, write_reg[1].value);
    else pass_cnt++;
    tick(); ex_wr = '0; tick(); tick();
    tot_cnt++;
    if (rd_data[1] !== 32'hB) $display("FAIL samedst_gpr7 got %h want b", rd_data[1]);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    do_reset();
    rd_addr[2] = 5'd0;
    ex_wr[0] = wr(1'b1, 5'd0, 32'hFFFF);
    #1;
    tot_cnt++;
    if (write_reg[1].valid !== 1'b0) $display("FAIL zero_ex_valid got %b want 0", write_reg[1].valid);
    else pass_cnt++;
    tick(); ex_wr = '0; #1;
    tot_cnt++;
    if (write_reg[3].valid !== 1'b0) $display("FAIL zero_mem_valid got %b want 0", write_reg[3].valid);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      tot_cnt++;
      if (rd_data[2] !== 32'h0) $display("FAIL zero_rd0 cycle %0d got %h want 0", c, rd_data[2]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stall_load();
    do_reset();
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    ex_wr[0] = wr(1'b1, 5'd4, 32'h44);
    tick();
    ex_wr[0] = wr(1'b1, 5'd3, 32'h0);
    tick();
    ex_wr = '0; stall = 1'b1;
    mem_ld_valid[0] = 1'b1; mem_ld_data[0] = 32'hCAFE;
    tick();
    mem_ld_valid = '0; mem_ld_data = '0;
    #1;
    tot_cnt++;
    if (write_reg[3] !== wr(1'b1, 5'd3, 32'hCAFE)) $display("FAIL stall_wr3 got %h want cafe", write_reg[3]);
    else pass_cnt++;
    tick();
    tot_cnt++;
    if (write_reg[3].value !== 32'hCAFE) $display("FAIL stall_wr3_hold got %h want cafe", write_reg[3].value);
    else pass_cnt++;
    tot_cnt++;
    if (write_reg[5] !== wr(1'b1, 5'd4, 32'h44)) $display("FAIL stall_wb_hold got %h", write_reg[5]);
    else pass_cnt++;
    tot_cnt++;
    if (rd_data[1] !== 32'h0 || rd_data[0] !== 32'h0)
      $display("FAIL stall_no_commit got %h/%h want 0/0", rd_data[1], rd_data[0]);
    else pass_cnt++;
    stall = 1'b0;
    tick();
    tot_cnt++;
    if (rd_data[1] !== 32'h44) $display("FAIL stall_release_gpr4 got %h want 44", rd_data[1]);
    else pass_cnt++;
    tick();
    tot_cnt++;
    if (rd_data[0] !== 32'hCAFE) $display("FAIL stall_release_gpr3 got %h want cafe", rd_data[0]);
    else pass_cnt++;
  endtask

  task automatic fill_pipe();
    ex_wr[0] = wr(1'b1, 5'd3, 32'h303); tick();
    ex_wr[0] = wr(1'b1, 5'd2, 32'h202); tick();
    ex_wr[0] = wr(1'b1, 5'd1, 32'h101);
  endtask

  task automatic test_flush_stall();
    do_reset();
    rd_addr = '{5'd0, 5'd3, 5'd2, 5'd1};
    fill_pipe();
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0; ex_wr = '0;
    #1;
    for (int i = 0; i < BYPASS_DEPTH; i++) begin
      tot_cnt++;
      if (write_reg[i].valid !== 1'b0) $display("FAIL flush_valid[%0d] got %b want 0", i, write_reg[i].valid);
      else pass_cnt++;
    end
    tot_cnt++;
    if (rd_data[2] !== 32'h303) $display("FAIL flush_gpr3 got %h want 303", rd_data[2]);
    else pass_cnt++;
    tick(); tick();
    tot_cnt++;
    if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0)
      $display("FAIL flush_killed got %h/%h want 0/0", rd_data[0], rd_data[1]);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    rd_addr = '{5'd0, 5'd3, 5'd2, 5'd1};
    tick();
    fill_pipe();
    ex_wr[1] = wr(1'b1, 5'd6, 32'h606);
    #2;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < BYPASS_DEPTH; i++) begin
      tot_cnt++;
      if (write_reg[i].valid !== 1'b0) $display("FAIL areset_valid[%0d] got %b want 0", i, write_reg[i].valid);
      else pass_cnt++;
    end
    tot_cnt++;
    if (rd_data[2] !== 32'h0) $display("FAIL areset_gpr3 got %h want 0", rd_data[2]);
    else pass_cnt++;
    resetn = 1'b1; ex_wr = '0;
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_same_dst();
    test_zero_reg();
    test_stall_load();
    test_flush_stall();
    test_async_reset();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
